// File: rtl/wb_pkg.sv
// Shared encodings for the KGP-RISC write-back path: instruction class, MemToReg select and
// sequencer state.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_ALU  = 2'b01,
        WB_LINK = 2'b10,
        WB_LOAD = 2'b11
    } wb_class_e;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_PC  = 2'b01;
    localparam logic [1:0] MTR_MEM = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StLoadReq,
        StLoadWait,
        StWrite
    } wb_state_e;

    // A class of NONE never reaches WRITE, so its select value is irrelevant.
    function automatic logic [1:0] class_to_mtr(input wb_class_e cls);
        logic [1:0] mtr;
        mtr = MTR_ALU;
        case (cls)
            WB_LINK: mtr = MTR_PC;
            WB_LOAD: mtr = MTR_MEM;
            default: mtr = MTR_ALU;
        endcase
        return mtr;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Load wait counter: loads 1 on the request cycle, counts while waiting, and flags when the
// count equals TIMEOUT. Cleared whenever neither load nor increment is requested.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = 8'd0;
        if (load_i) begin
            cnt_d = 8'd1;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 8'(TIMEOUT));

endmodule

// File: rtl/wb_sequencer.sv
// Write-back control sequencer: accepts retiring instructions, sequences loads through a
// request/ack exchange with timeout, and drives the register-file write port controls.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16,
    parameter bit          ZERO_RO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       wb_class,
    input  logic [4:0]       rd,
    output logic             mem_rd_en,
    input  logic             mem_ack,
    output logic [1:0]       MemToReg,
    output logic             reg_write,
    output logic [4:0]       reg_addr,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] wb_count
);

    wb_state_e        state_q, state_d;
    wb_class_e        cls_q, cls_d;
    logic [4:0]       rd_q, rd_d;
    logic             ready_q, ready_d;
    logic             rden_q, rden_d;
    logic [1:0]       mtr_q, mtr_d;
    logic             we_q, we_d;
    logic [4:0]       addr_q, addr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept, cnt_load, cnt_inc, cnt_tc, timeout, in_write;

    wb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_counter (
        .clk_i (clk),
        .rst_ni(rst),
        .load_i(cnt_load),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    // Handshake uses the registered ready, so nothing is accepted until one edge after reset.
    assign accept = instr_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        rd_d     = rd_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            StIdle, StWrite: begin
                if (accept) begin
                    cls_d = wb_class_e'(wb_class);
                    rd_d  = rd;
                    case (wb_class_e'(wb_class))
                        WB_NONE: state_d = StIdle;
                        WB_LOAD: state_d = StLoadReq;
                        default: state_d = StWrite;
                    endcase
                end else begin
                    state_d = StIdle;
                end
            end
            StLoadReq: begin
                cnt_load = 1'b1;
                state_d  = mem_ack ? StWrite : StLoadWait;
            end
            StLoadWait: begin
                cnt_inc = 1'b1;
                if (mem_ack) begin
                    state_d = StWrite;
                end else if (cnt_tc) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are precomputed from the next state so every port comes straight off a flop.
        in_write = (state_d == StWrite);
        we_d     = in_write && !(ZERO_RO && (rd_d == 5'd0));
        addr_d   = in_write ? rd_d : 5'd0;
        mtr_d    = in_write ? class_to_mtr(cls_d) : MTR_ALU;
        rden_d   = (state_d == StLoadReq);
        ready_d  = (state_d == StIdle) || (state_d == StWrite);
        err_d    = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
        count_d  = count_q + CNT_W'(we_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cls_q   <= WB_NONE;
            rd_q    <= 5'd0;
            ready_q <= 1'b0;
            rden_q  <= 1'b0;
            mtr_q   <= MTR_ALU;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            rden_q  <= rden_d;
            mtr_q   <= mtr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign instr_ready = ready_q;
    assign mem_rd_en   = rden_q;
    assign MemToReg    = mtr_q;
    assign reg_write   = we_q;
    assign reg_addr    = addr_q;
    assign timeout_err = err_q;
    assign wb_count    = count_q;

endmodule
